// File: rtl/fft_out_pkg.sv
// rtl/fft_out_pkg.sv - shared defaults, FSM encodings and bit-reversal helper
package fft_out_pkg;

   localparam int FFT_DATA_W = 16;
   localparam int FFT_N      = 64;
   localparam int FFT_LOG2N  = 6;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_DRAIN = 1'b1
   } r_state_t;

   function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(bits)) r = {r[30:0], idx[i]};
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - pair input stream and bin output stream of fft_out_reorder
interface fft_out_reorder_if #(
   parameter int DATA_W = 16,
   parameter int LOG2N  = 6
);
   logic              in_valid;
   logic              in_start;
   logic [DATA_W-1:0] in_re0;
   logic [DATA_W-1:0] in_im0;
   logic [DATA_W-1:0] in_re1;
   logic [DATA_W-1:0] in_im1;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_re;
   logic [DATA_W-1:0] out_im;
   logic [LOG2N-1:0]  out_index;
   logic              out_last;

   modport master (
      output in_valid, in_start, in_re0, in_im0, in_re1, in_im1, out_ready,
      input  out_valid, out_re, out_im, out_index, out_last
   );

   modport slave (
      input  in_valid, in_start, in_re0, in_im0, in_re1, in_im1, out_ready,
      output out_valid, out_re, out_im, out_index, out_last
   );
endinterface

// File: rtl/fft_pingpong_bank.sv
// rtl/fft_pingpong_bank.sv - one N-entry {re,im} bank, two write ports, one registered read port
module fft_pingpong_bank
   import fft_out_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W,
   parameter int N      = FFT_N,
   parameter int LOG2N  = FFT_LOG2N
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                we,
   input  logic [LOG2N-1:0]    wa0,
   input  logic [2*DATA_W-1:0] wd0,
   input  logic [LOG2N-1:0]    wa1,
   input  logic [2*DATA_W-1:0] wd1,
   input  logic                re,
   input  logic [LOG2N-1:0]    ra,
   output logic [2*DATA_W-1:0] rd
);

   logic [2*DATA_W-1:0] mem [N];

   // Storage is deliberately left unreset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa0] <= wd0;
         mem[wa1] <= wd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd <= '0;
      end else if (re) begin
         rd <= mem[ra];
      end
   end

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder of two-sample FFT output into natural bin order
module fft_out_reorder
   import fft_out_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W,
   parameter int N      = FFT_N,
   parameter int LOG2N  = FFT_LOG2N,
   parameter int BITREV = 1
) (
   input  logic              clk,
   input  logic              nrst,
   fft_out_reorder_if.slave  intf,
   output logic              overflow,
   output logic              busy
);

   localparam logic [LOG2N-2:0] W_ONE  = (LOG2N-1)'(1);
   localparam logic [LOG2N-2:0] W_LAST = (LOG2N-1)'(N/2-1);
   localparam logic [LOG2N-1:0] R_LAST = LOG2N'(N-1);
   localparam logic [LOG2N-1:0] R_PEN  = LOG2N'(N-2);

   w_state_t            w_state;
   r_state_t            r_state;
   logic [LOG2N-2:0]    wcnt;
   logic [LOG2N-1:0]    rcnt;
   logic [1:0]          full;
   logic                wbank;
   logic                rbank;
   logic                out_valid_q;
   logic                out_last_q;

   logic                wr_en;
   logic                wr_last;
   logic [LOG2N-2:0]    wr_pair;
   logic [LOG2N-1:0]    pos0, pos1, addr0, addr1;
   logic                hs;
   logic                rd_en;
   logic                rd_last;
   logic [LOG2N-1:0]    rd_addr;
   logic [2*DATA_W-1:0] rd_data [2];

   // Reordering happens on the write side so the drain is a plain linear read.
   always_comb begin
      wr_pair = (w_state == W_IDLE || intf.in_start) ? '0 : wcnt;
      pos0    = {wr_pair, 1'b0};
      pos1    = {wr_pair, 1'b1};
      addr0   = (BITREV != 0) ? LOG2N'(bitrev(32'(pos0), LOG2N)) : pos0;
      addr1   = (BITREV != 0) ? LOG2N'(bitrev(32'(pos1), LOG2N)) : pos1;
      wr_en   = intf.in_valid &&
                ((w_state == W_IDLE && intf.in_start && !full[wbank]) || w_state == W_FILL);
      wr_last = intf.in_valid && w_state == W_FILL && !intf.in_start && wcnt == W_LAST;
      hs      = out_valid_q && intf.out_ready;
      rd_en   = (r_state == R_IDLE && full[rbank]) ||
                (r_state == R_DRAIN && hs && rcnt != R_LAST);
      rd_addr = (r_state == R_IDLE) ? '0 : rcnt + 1'b1;
      rd_last = r_state == R_DRAIN && hs && rcnt == R_LAST;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_pingpong_bank #(.DATA_W(DATA_W), .N(N), .LOG2N(LOG2N)) u_bank (
         .clk  (clk),
         .nrst (nrst),
         .we   (wr_en && wbank == 1'(b)),
         .wa0  (addr0),
         .wd0  ({intf.in_re0, intf.in_im0}),
         .wa1  (addr1),
         .wd1  ({intf.in_re1, intf.in_im1}),
         .re   (rd_en && rbank == 1'(b)),
         .ra   (rd_addr),
         .rd   (rd_data[b])
      );
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         w_state  <= W_IDLE;
         wcnt     <= '0;
         wbank    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (intf.in_valid && intf.in_start) begin
                  wcnt <= W_ONE;
                  if (full[wbank]) begin
                     overflow <= 1'b1;
                     w_state  <= W_DROP;
                  end else begin
                     w_state  <= W_FILL;
                  end
               end
            end
            W_FILL: begin
               if (intf.in_valid) begin
                  if (intf.in_start) begin
                     wcnt <= W_ONE;
                  end else if (wcnt == W_LAST) begin
                     wcnt    <= '0;
                     wbank   <= ~wbank;
                     w_state <= W_IDLE;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            W_DROP: begin
               if (intf.in_valid) begin
                  if (intf.in_start) begin
                     wcnt <= W_ONE;
                  end else if (wcnt == W_LAST) begin
                     wcnt    <= '0;
                     w_state <= W_IDLE;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= R_IDLE;
         rcnt        <= '0;
         rbank       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (r_state == R_IDLE) begin
         if (full[rbank]) begin
            rcnt        <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            r_state     <= R_DRAIN;
         end
      end else if (hs) begin
         if (rcnt == R_LAST) begin
            rcnt        <= '0;
            rbank       <= ~rbank;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            r_state     <= R_IDLE;
         end else begin
            rcnt       <= rcnt + 1'b1;
            out_last_q <= (rcnt == R_PEN);
         end
      end
   end

   // Filling and draining always target different banks, so both updates may land together.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         full <= '0;
      end else begin
         if (wr_last) full[wbank] <= 1'b1;
         if (rd_last) full[rbank] <= 1'b0;
      end
   end

   assign intf.out_valid = out_valid_q;
   assign intf.out_last  = out_last_q;
   assign intf.out_index = rcnt;
   assign {intf.out_re, intf.out_im} = rd_data[rbank];
   assign busy = (|full) || (w_state != W_IDLE) || (r_state != R_IDLE);

endmodule
